// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  // Guards against a zero STAGES so an illegal setting still elaborates far enough to report it.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned stages);
    if (width < 1 || width > 64) return 1'b0;
    if (stages < 1 || stages > width) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple-carry adder slice; also exposes the carry into its msb.
module adder_chunk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(CW); i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[CW];
  assign o_cmsb = w_c[CW-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one chunk ripple per stage, valid/ready on both sides.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] ChunkOnes = WIDTH'((65'd1 << CW) - 65'd1);

  if (!params_legal(WIDTH, STAGES)) begin : g_param_err
    $error("adder_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // r_s[k] holds the partial sum in chunks 0..k and the untouched A chunks above it.
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_word_in [STAGES];
  logic [WIDTH-1:0]  w_b_in    [STAGES];
  logic [WIDTH-1:0]  w_s_nxt   [STAGES];
  logic [CW-1:0]     w_sum     [STAGES];
  logic              w_cmsb    [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_cout;

  op_e              w_op;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_adv;
  logic             w_ovf;

  assign w_op      = op_e'(in_sub);
  assign w_b_eff   = (w_op == OpSub) ? ~in_b : in_b;
  assign w_cin_eff = (w_op == OpSub) ? ~in_cin : in_cin;

  // The whole pipe moves as one; any stall freezes every stage.
  assign w_adv    = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_word_in[k] = in_a;
      assign w_b_in[k]    = w_b_eff;
      assign w_c_in[k]    = w_cin_eff;
      assign w_v_in[k]    = in_valid;
    end else begin : g_next
      assign w_word_in[k] = r_s[k-1];
      assign w_b_in[k]    = r_b[k-1];
      assign w_c_in[k]    = r_c[k-1];
      assign w_v_in[k]    = r_v[k-1];
    end

    adder_chunk #(
      .CW (CW)
    ) u_chunk (
      .i_a    (w_word_in[k][k*CW +: CW]),
      .i_b    (w_b_in[k][k*CW +: CW]),
      .i_cin  (w_c_in[k]),
      .o_sum  (w_sum[k]),
      .o_cout (w_cout[k]),
      .o_cmsb (w_cmsb[k])
    );

    assign w_s_nxt[k] = (w_word_in[k] & ~(ChunkOnes << (k*CW))) |
                        (WIDTH'(w_sum[k]) << (k*CW));
  end

  // Signed overflow: carry into the msb disagrees with carry out of it.
  assign w_ovf = w_cout[STAGES-1] ^ w_cmsb[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_s[k] <= '0;
      end
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        r_b[k] <= '0;
      end
    end else if (w_adv) begin
      r_v <= w_v_in;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        r_s[k] <= w_s_nxt[k];
        r_b[k] <= w_b_in[k];
        r_c[k] <= w_cout[k];
      end
      // Output registers only change when a real result lands, so bubbles never disturb them.
      if (w_v_in[STAGES-1]) begin
        r_s[STAGES-1] <= w_s_nxt[STAGES-1];
        r_c[STAGES-1] <= w_cout[STAGES-1];
        r_ovf         <= w_ovf;
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out_sum   = r_s[STAGES-1];
  assign out_cout  = r_c[STAGES-1];
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench: directed vectors, backpressure/reset sequences and exhaustive 4-bit runs.
module tb_adder_pipe;

  typedef struct packed {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  int checks = 0;
  int errors = 0;
  int small_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic m_rst_n, s_rst_n;
  logic m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_sum;

  adder_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst_n     (m_rst_n),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_a      (m_a),
    .in_b      (m_b),
    .in_cin    (m_cin),
    .in_sub    (m_sub),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_sum   (m_sum),
    .out_cout  (m_cout),
    .out_ovf   (m_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain signed/unsigned arithmetic; subtraction computed directly as a - b - cin.
  function automatic res_t model(input int unsigned w, input logic sub, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b);
    longint aa, bb, sa, sb, full, sres, half, modv;
    res_t r;
    modv = longint'(64'd1 << w);
    half = modv / 2;
    aa   = longint'(a) % modv;
    bb   = longint'(b) % modv;
    sa   = (aa >= half) ? aa - modv : aa;
    sb   = (bb >= half) ? bb - modv : bb;
    if (sub) begin
      full   = aa - bb - longint'(cin);
      sres   = sa - sb - longint'(cin);
      r.cout = (full >= 0);
    end else begin
      full   = aa + bb + longint'(cin);
      sres   = sa + sb + longint'(cin);
      r.cout = (full >= modv);
    end
    r.sum = 16'(((full % modv) + modv) % modv);
    r.ovf = (sres >= half) || (sres < -half);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Streams n transactions; bp_mode uses a=b=i with a 3-cycle stall on the first result.
  task automatic run_stream(input int n, input bit bp_mode);
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, cyc = 0, stall = 0;
    bit first_seen = 1'b0;
    while ((sent < n || q.size() > 0) && cyc < 400) begin
      if (bp_mode && !first_seen && m_out_valid) begin
        first_seen = 1'b1;
        stall      = 3;
      end
      if (sent < n && (bp_mode || $urandom_range(4) != 0)) begin
        m_in_valid = 1'b1;
        if (bp_mode) begin
          m_a = 16'(sent + 1); m_b = 16'(sent + 1); m_sub = 1'b0; m_cin = 1'b0;
        end else begin
          m_a = 16'($urandom); m_b = 16'($urandom);
          m_sub = 1'($urandom); m_cin = 1'($urandom);
        end
      end else begin
        m_in_valid = 1'b0;
      end
      m_out_ready = bp_mode ? (stall == 0) : 1'($urandom);
      #1;
      if (bp_mode && stall > 0) begin
        check("bp_hold_sum", m_sum, 16'd2);
        check("bp_in_ready_low", m_in_ready, 1'b0);
        check("bp_hold_valid", m_out_valid, 1'b1);
      end
      if (m_out_valid && m_out_ready) begin
        check("stream_underflow", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check(bp_mode ? "bp_result" : "rand_result", {m_sum, m_cout, m_ovf},
                {e.sum, e.cout, e.ovf});
          got++;
        end
      end
      if (m_in_valid && m_in_ready) begin
        q.push_back(model(16, m_sub, m_cin, m_a, m_b));
        sent++;
      end
      if (stall > 0) stall--;
      tick();
      cyc++;
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    check(bp_mode ? "bp_complete" : "rand_complete", (sent == n) && (q.size() == 0), 1'b1);
    if (bp_mode) check("bp_count", got, 6);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int unsigned St = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic iv, ir, ic, is, ov, orr, oc, oo;
    logic [3:0] ia, ib, os;
    res_t q[$];

    adder_pipe #(.WIDTH(4), .STAGES(St)) u_small (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (ia),
      .in_b      (ib),
      .in_cin    (ic),
      .in_sub    (is),
      .out_valid (ov),
      .out_ready (orr),
      .out_sum   (os),
      .out_cout  (oc),
      .out_ovf   (oo)
    );

    initial begin
      int idx;
      int cyc;
      res_t e;
      logic [9:0] code;
      idx = 0; cyc = 0;
      iv = 1'b0; ia = '0; ib = '0; ic = 1'b0; is = 1'b0; orr = 1'b0;
      @(posedge s_rst_n);
      while ((idx < 1024 || q.size() > 0) && cyc < 20000) begin
        tick();
        cyc++;
        code = idx[9:0];
        {is, ic, ia, ib} = code;
        iv  = (idx < 1024) && ($urandom_range(3) != 0);
        orr = ($urandom_range(3) != 0);
        #1;
        if (ov && orr) begin
          check($sformatf("s%0d_underflow", St), q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("s%0d_result", St), {os, oc, oo}, {e.sum[3:0], e.cout, e.ovf});
          end
        end
        if (iv && ir) begin
          q.push_back(model(4, is, ic, {12'd0, ia}, {12'd0, ib}));
          idx++;
        end
      end
      check($sformatf("s%0d_complete", St), (idx == 1024) && (q.size() == 0), 1'b1);
      small_done++;
    end
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    m_rst_n = 1'b0; s_rst_n = 1'b0;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b0;
    tick();
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_out_sum", m_sum, 16'h0);
    check("rst_out_cout", m_cout, 1'b0);
    check("rst_out_ovf", m_ovf, 1'b0);
    check("rst_in_ready", m_in_ready, 1'b1);
    repeat (2) tick();
    m_rst_n = 1'b1; s_rst_n = 1'b1;
    tick();

    m_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {m_sub, m_cin, m_a, m_b} = {tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b};
      m_in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), m_in_ready, 1'b1);
      tick();
      m_in_valid = 1'b0;
      repeat (2) tick();
      check($sformatf("vec%0d_early", i), m_out_valid, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), m_out_valid, 1'b1);
      check($sformatf("vec%0d_sum", i), m_sum, tbl[i].sum);
      check($sformatf("vec%0d_cout", i), m_cout, tbl[i].cout);
      check($sformatf("vec%0d_ovf", i), m_ovf, tbl[i].ovf);
      tick();
    end

    run_stream(6, 1'b1);

    // Reset with three transactions in flight; none may emerge afterwards.
    for (int i = 1; i <= 3; i++) begin
      m_a = 16'(10 * i); m_b = 16'(i); m_sub = 1'b0; m_cin = 1'b0; m_in_valid = 1'b1;
      tick();
    end
    m_in_valid = 1'b0;
    m_rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", m_out_valid, 1'b0);
    check("mid_rst_sum", m_sum, 16'h0);
    check("mid_rst_in_ready", m_in_ready, 1'b1);
    tick();
    m_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("post_rst_no_stale", m_out_valid, 1'b0);
    end
    m_a = 16'd3; m_b = 16'd4; m_in_valid = 1'b1;
    tick();
    m_in_valid = 1'b0;
    repeat (2) tick();
    check("post_rst_early", m_out_valid, 1'b0);
    tick();
    check("post_rst_valid", m_out_valid, 1'b1);
    check("post_rst_sum", m_sum, 16'd7);
    tick();

    run_stream(40, 1'b0);

    for (int c = 0; c < 30000 && small_done < 3; c++) @(posedge clk);
    check("small_runs_done", small_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor; next generation of the team's 4-bit ripple full adder.
- Splits the operands into STAGES equal chunks. One chunk-wide ripple add is done per pipeline stage, and the carry is registered between stages.
- Uses a valid/ready stream handshake on both sides, so it can sit between datapath blocks that apply backpressure.
- Outputs carry-out and a signed-overflow flag, and supports add and subtract modes.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES; legal range 1..64.
- STAGES, 4, number of pipeline stages, which is also the latency in cycles; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept an input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (add) or borrow-in (subtract).
- in_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry-out; in subtract mode this is the inverted borrow (1 = no borrow).
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Chunk width: CW = WIDTH/STAGES. If the parameters are illegal, elaboration fails with $error.
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Subtract: b is replaced by ~b and the carry-in by ~cin, so sum = a - b - cin mod 2^WIDTH.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted-or-not B.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds chunk k (bits k*CW +: CW) of A and B' plus the carry from stage k-1 (stage 0 uses the effective carry-in).
  - It registers that partial sum, its carry-out, and every still-unused upper operand chunk.
  - Lower partial sums are carried forward alongside the data (skew/deskew registers), so all WIDTH result bits appear together in the final register.
- Per-stage valid bit v[k] travels with the data. out_valid = v[STAGES-1].
- Advance rule:
  - adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1, every stage shifts by one and stage 0 captures the inputs; v[0] <= in_valid.
  - When adv=0, every register holds, including out_sum/out_cout/out_ovf, which stay stable while out_valid=1 and out_ready=0.
  - The whole pipeline stalls together; bubbles are not collapsed.
- Latency: an input accepted on cycle n (in_valid && in_ready) appears with out_valid=1 on cycle n+STAGES, absent stalls.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Simultaneous events:
  - Output handshake and input accept in the same cycle is legal and normal; the pipeline shifts once.
  - in_valid=0 inserts a bubble that advances like data.
- Reset (rst_n low, any time, including mid-operation):
  - All v[k], out_valid, out_sum, out_cout and out_ovf go to 0 immediately.
  - in_ready is 1 during and after reset.
  - In-flight transactions are discarded; there is no partial output after deassertion.
- STAGES=1 degenerates to one registered full-width add with latency 1.
- Data registers with v[k]=0 are don't-care internally, but outputs are reset to 0 and hold their last value otherwise.

Decomposition:
- Package adder_pkg:
  - localparam function for the chunk width.
  - Typedef for the operation mode (ADD=0, SUB=1).
  - Parameter-legality check function.
- Sub-module adder_chunk: combinational CW-bit ripple adder (a, b, cin -> sum, cout, plus the msb carry-in for overflow).
  - Instantiated STAGES times by a generate loop.
  - Top level contains only the registers, handshake logic and generate loop.

Test Plan:
- WIDTH=16 STAGES=4, add a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 -> 4 cycles later out_sum=16'h0000, out_cout=1, out_ovf=0.
- Subtract a=16'h0005, b=16'h0007, cin=0 -> out_sum=16'hFFFE, out_cout=0 (borrow), out_ovf=0. Then subtract a=16'h8000, b=16'h0001 -> out_sum=16'h7FFF, out_ovf=1.
- Add a=16'h7FFF, b=16'h0001 -> out_sum=16'h8000, out_ovf=1, out_cout=0. Also check that a carry ripples across all 4 chunk boundaries (16'h0FFF + 16'h0001 = 16'h1000).
- Backpressure: stream 6 back-to-back adds (i+i, i=1..6) and drop out_ready for 3 cycles after the first result.
  - in_ready must fall in the same cycles.
  - out_sum must hold at 2 until released.
  - All six results 2,4,...,12 must arrive in order with no loss or duplicates.
- Reset mid-operation: accept 3 transactions, assert rst_n=0 for 1 cycle before any output -> out_valid=0, out_sum=0, and no stale result ever emerges. A new add 3+4 afterwards -> 7 after 4 cycles.
- Exhaustive check at WIDTH=4 with STAGES=1, 2 and 4: all 2×2×16×16 combinations of sub, cin, a and b, with random out_ready, compared against a behavioural model (sum, cout, ovf) via a scoreboard.
